bounce_gen: RTL

Pixel source for the 640 x 480 / 8-colour VGA generator: it consumes the generator's `hpos`, `vpos`, `active` and `tick`, and returns the 3-bit RGB `pixel` for the current position. It draws a white one-pixel frame border and a coloured square "ball" on a black background. Once per frame, during vertical blanking, a small state machine moves the ball, bounces it off the screen edges and cycles its colour on each bounce.

---
 rtl/bounce_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bounce_gen.sv
// bounce_gen: pixel source for a 640x480 8-colour VGA generator.
// Draws a white one-pixel frame border and a coloured square ball on black.
// Once per frame (on tick, during vertical blanking) a three-state machine
// moves the ball one STEP per axis, reflects it off the screen edges and
// advances its colour on every bounce.
module bounce_gen #(
   parameter int SIZE   = 16,
   parameter int STEP   = 2,
   parameter int X_INIT = 100,
   parameter int Y_INIT = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       active,
   input  logic       tick,
   input  logic       pause,
   output logic [2:0] pixel,
   output logic [7:0] bounce_count
);

   // Furthest top-left position that keeps the whole ball on screen.
   localparam int X_LIM = 640 - SIZE;
   localparam int Y_LIM = 480 - SIZE;

   // Edge arithmetic is done at 11 bits so bx + SIZE never wraps.
   localparam logic [10:0] X_MAX11 = 11'(X_LIM);
   localparam logic [10:0] Y_MAX11 = 11'(Y_LIM);
   localparam logic [9:0]  X_MAX10 = 10'(X_LIM);
   localparam logic [9:0]  Y_MAX10 = 10'(Y_LIM);
   localparam logic [10:0] STEP11  = 11'(STEP);
   localparam logic [9:0]  STEP10  = 10'(STEP);
   localparam logic [10:0] SIZE11  = 11'(SIZE);
   localparam logic [9:0]  X_RST   = 10'(X_INIT);
   localparam logic [9:0]  Y_RST   = 10'(Y_INIT);

   localparam logic [1:0] S_WAIT  = 2'd0;
   localparam logic [1:0] S_UPD_X = 2'd1;
   localparam logic [1:0] S_UPD_Y = 2'd2;

   logic [1:0] state_q, state_d;
   logic [9:0] bx_q, bx_d;
   logic [9:0] by_q, by_d;
   logic       dx_q, dx_d;
   logic       dy_q, dy_d;
   logic [2:0] color_q, color_d;
   logic [7:0] bounce_count_q, bounce_count_d;
   logic       bounce;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one X step then one Y step per accepted tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT:  if (tick && !pause) state_d = S_UPD_X;
         S_UPD_X: state_d = S_UPD_Y;
         S_UPD_Y: state_d = S_WAIT;
         default: state_d = S_WAIT;
      endcase
   end

   // Ball position, direction, colour and bounce counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bx_q           <= X_RST;
         by_q           <= Y_RST;
         dx_q           <= 1'b1;
         dy_q           <= 1'b1;
         color_q        <= 3'b001;
         bounce_count_q <= 8'd0;
      end else begin
         bx_q           <= bx_d;
         by_q           <= by_d;
         dx_q           <= dx_d;
         dy_q           <= dy_d;
         color_q        <= color_d;
         bounce_count_q <= bounce_count_d;
      end
   end

   // Move/reflect the ball on the axis selected by the state; a bounce
   // advances the colour (skipping black) and the bounce counter.
   always_comb begin
      bx_d           = bx_q;
      by_d           = by_q;
      dx_d           = dx_q;
      dy_d           = dy_q;
      color_d        = color_q;
      bounce_count_d = bounce_count_q;
      bounce         = 1'b0;
      case (state_q)
         S_UPD_X: begin
            if (dx_q) begin
               if ({1'b0, bx_q} + STEP11 >= X_MAX11) begin
                  bx_d   = X_MAX10;
                  dx_d   = 1'b0;
                  bounce = 1'b1;
               end else begin
                  bx_d = bx_q + STEP10;
               end
            end else begin
               if ({1'b0, bx_q} <= STEP11) begin
                  bx_d   = 10'd0;
                  dx_d   = 1'b1;
                  bounce = 1'b1;
               end else begin
                  bx_d = bx_q - STEP10;
               end
            end
         end
         S_UPD_Y: begin
            if (dy_q) begin
               if ({1'b0, by_q} + STEP11 >= Y_MAX11) begin
                  by_d   = Y_MAX10;
                  dy_d   = 1'b0;
                  bounce = 1'b1;
               end else begin
                  by_d = by_q + STEP10;
               end
            end else begin
               if ({1'b0, by_q} <= STEP11) begin
                  by_d   = 10'd0;
                  dy_d   = 1'b1;
                  bounce = 1'b1;
               end else begin
                  by_d = by_q - STEP10;
               end
            end
         end
         default: ;
      endcase
      if (bounce) begin
         color_d        = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
         bounce_count_d = bounce_count_q + 8'd1;
      end
   end

   logic [10:0] hpos_w, vpos_w, bx_w, by_w;
   logic        in_ball, on_border;

   // Pixel colour: blanking, then ball (wins over border), then border.
   always_comb begin
      hpos_w    = {1'b0, hpos};
      vpos_w    = {1'b0, vpos};
      bx_w      = {1'b0, bx_q};
      by_w      = {1'b0, by_q};
      in_ball   = (hpos_w >= bx_w) && (hpos_w < bx_w + SIZE11) &&
                  (vpos_w >= by_w) && (vpos_w < by_w + SIZE11);
      on_border = (hpos == 10'd0) || (hpos == 10'd639) ||
                  (vpos == 10'd0) || (vpos == 10'd479);
      if (!active) begin
         pixel = 3'b000;
      end else if (in_ball) begin
         pixel = color_q;
      end else if (on_border) begin
         pixel = 3'b111;
      end else begin
         pixel = 3'b000;
      end
   end

   assign bounce_count = bounce_count_q;

endmodule
